// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end feeding a single UART transmitter.
// Each accepted character is sent as one start bit, DATA_WIDTH data bits (LSB first) and STOP_BITS stop periods.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  tx_clk_en,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  grant_id
);
  localparam int               CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q, state_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    grant_id_q, grant_id_d;
  logic                    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]              stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    sel;
  logic                    accept;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant_q;
    end
  end

  always_comb begin
    req0_ready = ~rst && (state_q == IDLE) && ~sel && req0_valid;
    req1_ready = ~rst && (state_q == IDLE) &&  sel && req1_valid;
    accept     = req0_ready | req1_ready;
  end

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shift_d      = shift_q;
    case (state_q)
      IDLE: begin
        // A strobe on the acceptance edge is deliberately ignored here.
        if (accept) begin
          shift_d      = sel ? req1_data : req0_data;
          last_grant_d = sel;
          grant_id_d   = sel;
          busy_d       = 1'b1;
          state_d      = START;
        end
      end
      START: begin
        if (tx_clk_en) begin
          tx_d      = 1'b0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tx_clk_en) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = '0;
            state_d    = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        // The closing strobe also re-drives the line high, so every stop period is full length.
        if (tx_clk_en) begin
          tx_d = 1'b1;
          if (stop_cnt_q == LAST_STOP) begin
            stop_cnt_d = '0;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      shift_q      <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-position reference model checked every cycle,
// a ready-truth table, directed corner sequences and a randomized run.
module tb_uart_tx_arbiter;
  localparam int DW        = 8;
  localparam int FRAME_LEN = 2 + DW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, en = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0, v0b = 1'b0, v1b = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0, d0b = '0, d1b = '0;
  logic          r0, r1, tx, busy, gid;
  logic          r0b, r1b, tx2, busy2, gid2;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut (
    .clk_50m(clk), .rst(rst), .tx_clk_en(en),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .tx(tx), .busy(busy), .grant_id(gid)
  );

  uart_tx_arbiter #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut2 (
    .clk_50m(clk), .rst(rst), .tx_clk_en(en),
    .req0_valid(v0b), .req0_data(d0b), .req0_ready(r0b),
    .req1_valid(v1b), .req1_data(d1b), .req1_ready(r1b),
    .tx(tx2), .busy(busy2), .grant_id(gid2)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: tracks only "idle or N strobes into a frame of known bits".
  bit      m_busy, m_tx, m_grant, m_last;
  logic [DW-1:0] m_data;
  int      m_pos;

  function automatic void model_reset();
    m_busy = 0; m_tx = 1; m_grant = 0; m_last = 1; m_data = '0; m_pos = 0;
  endfunction

  // Line level after the k-th strobe of a frame (k = 1 is the start bit).
  function automatic bit frame_bit(input logic [DW-1:0] d, input int k);
    if (k == 1) return 1'b0;
    if (k >= 2 && k <= DW + 1) return d[k-2];
    return 1'b1;
  endfunction

  int cyc = 0;
  bit accepted;
  int r0_cnt, r1_cnt, r0b_cnt, idle_cycles, busy_strobes, busy2_strobes;
  int tx_log[$];
  int tx2_log[$];
  int grant_log[$];

  task automatic clear_logs();
    r0_cnt = 0; r1_cnt = 0; r0b_cnt = 0; idle_cycles = 0;
    busy_strobes = 0; busy2_strobes = 0;
    tx_log.delete(); tx2_log.delete(); grant_log.delete();
  endtask

  function automatic bit per(input int p);
    return (cyc % p) == (p - 1);
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic tick(input bit s);
    bit sel, er0, er1, b_pre, r0_pre, r1_pre, b2_pre, r0b_pre;
    en = s;
    #2;
    sel = (v0 && v1) ? !m_last : v1;
    er0 = !rst && !m_busy && v0 && !sel;
    er1 = !rst && !m_busy && v1 && sel;
    chk("req0_ready", r0, er0);
    chk("req1_ready", r1, er1);
    b_pre = busy; r0_pre = r0; r1_pre = r1; b2_pre = busy2; r0b_pre = r0b;
    @(posedge clk);
    if (rst) model_reset();
    else if (!m_busy) begin
      if (er0 || er1) begin
        m_busy = 1; m_grant = sel; m_last = sel; m_data = sel ? d1 : d0; m_pos = 0;
      end
    end else if (s) begin
      m_pos++;
      m_tx = frame_bit(m_data, m_pos);
      if (m_pos == FRAME_LEN) m_busy = 0;
    end
    #1;
    chk("tx", tx, m_tx);
    chk("busy", busy, m_busy);
    chk("grant_id", gid, m_grant);
    accepted = r0_pre || r1_pre;
    if (r0_pre) r0_cnt++;
    if (r1_pre) r1_cnt++;
    if (r0b_pre) r0b_cnt++;
    if (accepted) grant_log.push_back(gid);
    if (!b_pre) idle_cycles++;
    if (s) begin
      tx_log.push_back(tx);
      tx2_log.push_back(tx2);
      if (b_pre) busy_strobes++;
      if (b2_pre) busy2_strobes++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; v0 = 0; v1 = 0; v0b = 0; v1b = 0;
    tick(0);
    tick(0);
    rst = 0;
  endtask

  task automatic wait_idle(input int p, input int bound, input string name);
    int n = 0;
    while ((busy || busy2) && n < bound) begin
      tick(per(p));
      n++;
    end
    chk(name, busy || busy2, 0);
  endtask

  typedef struct {
    bit phase; bit rst; bit v0; bit v1; bit r0; bit r1;
  } vec_t;
  vec_t vecs[8];

  // Ready is combinational, so table rows are applied inside one clock low phase.
  task automatic run_table(input bit ph);
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        rst = vecs[i].rst; v0 = vecs[i].v0; v1 = vecs[i].v1;
        #1;
        chk($sformatf("table%0d_req0_ready", i), r0, vecs[i].r0);
        chk($sformatf("table%0d_req1_ready", i), r1, vecs[i].r1);
      end
    end
    rst = 0; v0 = 0; v1 = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp55[11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    int exp5a[11] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
    int n;
    int idle_b2b;

    vecs[0] = '{0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 1, 0, 1, 0};
    vecs[2] = '{0, 0, 0, 1, 0, 1};
    vecs[3] = '{0, 0, 1, 1, 1, 0};
    vecs[4] = '{0, 1, 1, 1, 0, 0};
    vecs[5] = '{0, 1, 0, 1, 0, 0};
    vecs[6] = '{1, 0, 1, 1, 0, 1};
    vecs[7] = '{1, 0, 1, 0, 1, 0};

    model_reset();
    do_reset();
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_grant_id", gid, 0);
    run_table(0);

    // Single request, 0x55, strobe every 16 cycles.
    clear_logs();
    cyc = 0;
    v0 = 1; d0 = 8'h55;
    tick(per(16));
    v0 = 0; d0 = 8'hEE;
    wait_idle(16, 16 * 14, "single_idle_bound");
    repeat (40) tick(per(16));
    chk("single_ready_pulses", r0_cnt, 1);
    chk("single_busy_strobes", busy_strobes, 11);
    for (int i = 0; i < 11; i++) chk($sformatf("single_tx_bit%0d", i), qget(tx_log, i), exp55[i]);
    run_table(1);

    // Tie out of reset, then fairness over six back-to-back frames.
    do_reset();
    clear_logs();
    cyc = 0;
    v0 = 1; v1 = 1; d0 = 8'hA1; d1 = 8'h3C;
    n = 0;
    while (grant_log.size() < 6 && n < 1500) begin
      tick(per(16));
      n++;
    end
    idle_b2b = idle_cycles;
    v0 = 0; v1 = 0;
    wait_idle(16, 16 * 14, "fair_idle_bound");
    chk("fair_frames", grant_log.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("fair_grant%0d", i), qget(grant_log, i), i % 2);
    chk("fair_req0_pulses", r0_cnt, 3);
    chk("fair_req1_pulses", r1_cnt, 3);
    chk("fair_idle_cycles", idle_b2b, 6);

    // Strobe on the acceptance edge of requester 1.
    v1 = 1; d1 = 8'h96;
    tick(1);
    v1 = 0;
    chk("accstrobe_accepted", accepted, 1);
    chk("accstrobe_grant", gid, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0);
      chk($sformatf("accstrobe_hold%0d", i), tx, 1);
    end
    tick(1);
    chk("accstrobe_start_bit", tx, 0);
    wait_idle(8, 8 * 14, "accstrobe_idle_bound");

    // Reset after the fourth data bit, then a clean frame.
    v0 = 1; d0 = 8'hC3;
    tick(0);
    v0 = 0;
    repeat (5) begin
      tick(0); tick(0); tick(1);
    end
    tick(0);
    rst = 1;
    tick(0);
    rst = 0;
    chk("midreset_tx", tx, 1);
    chk("midreset_busy", busy, 0);
    repeat (12) begin
      tick(per(3));
      chk("midreset_no_rerequest", busy, 0);
    end
    clear_logs();
    cyc = 0;
    v1 = 1; d1 = 8'h5A;
    tick(0);
    v1 = 0;
    wait_idle(4, 4 * 14, "clean_idle_bound");
    chk("clean_req1_pulses", r1_cnt, 1);
    for (int i = 0; i < 11; i++) chk($sformatf("clean_tx_bit%0d", i), qget(tx_log, i), exp5a[i]);

    // Two stop bits, 0xFF, back-to-back frames on the second instance.
    clear_logs();
    cyc = 0;
    v0b = 1; d0b = 8'hFF;
    n = 0;
    while (r0b_cnt < 2 && n < 200) begin
      tick(per(4));
      n++;
    end
    v0b = 0;
    wait_idle(4, 4 * 16, "sb2_idle_bound");
    chk("sb2_accepts", r0b_cnt, 2);
    chk("sb2_busy_strobes", busy2_strobes, 24);
    for (int i = 0; i < 24; i++)
      chk($sformatf("sb2_tx_strobe%0d", i), qget(tx2_log, i), (i == 0 || i == 12) ? 0 : 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) v0 = ~v0;
      if ($urandom_range(7) == 0) v1 = ~v1;
      d0 = DW'($urandom);
      d1 = DW'($urandom);
      rst = ($urandom_range(399) == 0);
      tick($urandom_range(2) == 0);
    end
    rst = 0; v0 = 0; v1 = 0;
    wait_idle(2, 2 * 14, "random_idle_bound");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per character, LSB transmitted first.
REQ-002 Parameter STOP_BITS, default 1, stop-bit periods per frame; legal values 1 or 2.
REQ-003 clk_50m  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tx_clk_en  input  1  one-cycle bit-rate strobe from the baud generator (Txclk_en).
REQ-006 req0_valid  input  1  requester 0 has a character to send.
REQ-007 req0_data  input  DATA_WIDTH  requester 0 character; sampled only on acceptance.
REQ-008 req0_ready  output  1  requester 0 character accepted this cycle.
REQ-009 req1_valid  input  1  requester 1 has a character to send.
REQ-010 req1_data  input  DATA_WIDTH  requester 1 character; sampled only on acceptance.
REQ-011 req1_ready  output  1  requester 1 character accepted this cycle.
REQ-012 tx  output  1  serial line; idle high; 8N1-style framing.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 grant_id  output  1  index of the requester whose character is in flight; holds its value when IDLE.

Function
REQ-015 FSM states are IDLE, START, DATA and STOP; there are no other states.
REQ-016 reqN_ready is combinational and is high only in IDLE, only for the selected requester, and only while that requester's valid is high.
REQ-017 Selection in IDLE: if exactly one valid is high, that requester is selected; if both are high, the requester other than last_grant is selected (round-robin).
REQ-018 Acceptance (valid and ready high at a clock edge) latches the selected data into the shift register, updates last_grant and grant_id, and moves IDLE to START.
REQ-019 tx changes only on edges where tx_clk_en=1; outside IDLE, no state other than the FSM advances without a strobe.
REQ-020 START: on a strobe, tx<=0, bit_cnt<=0 and the FSM moves to DATA.
REQ-021 DATA: on each strobe, tx<=data[bit_cnt] and bit_cnt increments; the strobe that drives bit DATA_WIDTH-1 moves the FSM to STOP.
REQ-022 STOP: on each strobe, tx<=1 and stop_cnt increments; the strobe on which stop_cnt equals STOP_BITS moves the FSM to IDLE.
REQ-023 A frame occupies exactly 2+DATA_WIDTH+STOP_BITS strobes from acceptance to IDLE (11 with default parameters), giving full-length start, data and stop periods.
REQ-024 A strobe coinciding with the acceptance edge is ignored; the start bit begins at the next strobe after acceptance.
REQ-025 Acceptance is possible on the first cycle back in IDLE, so back-to-back frames have no extra idle bit.
REQ-026 A requester deasserting valid without a handshake has no effect; data changes while not accepted are ignored.
REQ-027 The in-flight character is immune to requester input changes; no new acceptance occurs while busy=1.
REQ-028 bit_cnt is $clog2(DATA_WIDTH) bits wide, stop_cnt is 2 bits wide, and neither counter wraps within a frame.

Reset
REQ-029 On rst=1 at an edge: state=IDLE, tx=1, busy=0, grant_id=0, last_grant=1 (requester 0 wins the first tie), counters=0, shift register=0.
REQ-030 Reset mid-frame aborts the frame; tx returns high on the next cycle, the character is discarded and it is not re-requested.
REQ-031 While rst=1, req0_ready=0 and req1_ready=0.

Verification
REQ-032 Single request: req0_valid with data 0x55, strobe every 16 cycles -> req0_ready pulses once; tx shows 0,1,0,1,0,1,0,1,0,1 then high, one bit per strobe; busy high for 11 strobes.
REQ-033 Tie: both valid out of reset, data 0xA1 and 0x3C held -> req0 served first, req1 next; frames are back-to-back; grant_id goes 0 then 1; each ready pulses exactly once.
REQ-034 Fairness: both valid continuously for 6 frames -> grants alternate 0,1,0,1,0,1.
REQ-035 Strobe on acceptance edge: tx_clk_en=1 in the same cycle req1 is accepted -> tx stays high until the next strobe, then the start bit begins.
REQ-036 Reset after the 4th data bit of a frame -> tx=1 and busy=0 on the following cycle; the next request starts a clean frame.
REQ-037 STOP_BITS=2, data 0xFF -> tx stays high for 2 full strobe periods after the last data bit before the next start bit.
